rr_arb: RTL and testbench

Parameterised round-robin arbiter producing a one-hot grant vector.
- Sits directly upstream of the one-hot-to-binary encoder (`enc`): `gnt_o` feeds `enc.x_i` to form the winning index for datapath muxing.
- Fairness comes from a registered last-grant pointer that advances only on accepted grants.
- An optional lock holds a grant across multi-beat transfers.

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_arb_if.sv | 21 ++
 rtl/rr_arb_pri_arb.sv | 21 ++
 rtl/rr_arb.sv | 72 +++++++
 tb/tb_rr_arb.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared arbitration definitions: width limit and the lowest-set-bit isolator
// used by the fixed-priority stages of this and other arbiters.
package rr_arb_pkg;

  // Widest request vector the helper supports; arbiters zero-extend into it.
  localparam int LSB_W = 32;

  function automatic logic [LSB_W-1:0] lsb_onehot(input logic [LSB_W-1:0] vec);
    return vec & (-vec);
  endfunction

endpackage

// File: rtl/rr_arb_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface rr_arb_if #(parameter int N = 4);

  logic [N-1:0] req_i;
  logic         ack_i;
  logic         lock_i;
  logic [N-1:0] gnt_o;
  logic         gnt_vld_o;
  logic         locked_o;

  modport master (
    output req_i, ack_i, lock_i,
    input  gnt_o, gnt_vld_o, locked_o
  );

  modport slave (
    input  req_i, ack_i, lock_i,
    output gnt_o, gnt_vld_o, locked_o
  );

endinterface

// File: rtl/rr_arb_pri_arb.sv
// Fixed-priority arbiter, LSB wins; purely combinational.
module pri_arb
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // N must not exceed LSB_W; narrower vectors are zero-extended into the helper.
  generate
    if (N < LSB_W) begin : g_ext
      logic [LSB_W-N-1:0] unused_hi;
      assign {unused_hi, gnt} = lsb_onehot({{(LSB_W-N){1'b0}}, req});
    end else begin : g_full
      assign gnt = lsb_onehot(req);
    end
  endgenerate

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with one-hot grant, last-accepted pointer and optional
// grant lock held across multi-beat transfers.
module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic     clk,
  input  logic     rst,
  rr_arb_if.slave  bus
);

  logic [N-1:0] last_q;
  logic [N-1:0] lock_owner_q;
  logic         lock_q;

  logic [N-1:0] mask;
  logic [N-1:0] req_masked;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_plain;
  logic [N-1:0] gnt_rr;
  logic [N-1:0] gnt;
  logic         owner_hit;
  logic         accept;

  // Thermometer of positions strictly above the last accepted requester.
  assign mask       = ~(last_q | (last_q - N'(1)));
  assign req_masked = bus.req_i & mask;

  pri_arb #(.N(N)) u_pri_masked (
    .req (req_masked),
    .gnt (gnt_masked)
  );

  pri_arb #(.N(N)) u_pri_plain (
    .req (bus.req_i),
    .gnt (gnt_plain)
  );

  assign gnt_rr    = (|gnt_masked) ? gnt_masked : gnt_plain;
  assign owner_hit = lock_q & (|(bus.req_i & lock_owner_q));

  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt = owner_hit ? lock_owner_q : gnt_rr;
    end
  end

  assign accept        = (|gnt) & bus.ack_i;
  assign bus.gnt_o     = gnt;
  assign bus.gnt_vld_o = |gnt;
  assign bus.locked_o  = ~rst & owner_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= {1'b1, {(N-1){1'b0}}};
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else if (accept) begin
      last_q <= gnt;
      lock_q <= bus.lock_i;
      if (bus.lock_i) begin
        lock_owner_q <= gnt;
      end
    end else if (!owner_hit) begin
      // Owner dropped its request (or nothing requested): release the lock.
      lock_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb.sv
// Self-checking bench for rr_arb: circular-search reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_rr_arb;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_arb_if #(.N(N)) bus ();

  rr_arb #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index-based state, circular search from the last winner.
  int m_last;
  int m_owner;
  bit m_lock;
  int wait_cnt [N];

  function automatic int model_idx(input logic [N-1:0] r);
    if (m_lock && r[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_last  <= N - 1;
      m_lock  <= 1'b0;
      m_owner <= 0;
    end else begin
      w = model_idx(bus.req_i);
      if (w >= 0 && bus.ack_i) begin
        m_last <= w;
        m_lock <= bus.lock_i;
        if (bus.lock_i) m_owner <= w;
      end else if (!(m_lock && bus.req_i[m_owner])) begin
        m_lock <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, plus starvation bookkeeping.
  always @(negedge clk) begin
    int            w;
    logic [N-1:0]  exp_gnt;
    logic          exp_lck;
    w       = rst ? -1 : model_idx(bus.req_i);
    exp_gnt = (w >= 0) ? N'(1) << w : '0;
    exp_lck = !rst && m_lock && bus.req_i[m_owner];
    chk("m_gnt",    32'(bus.gnt_o), 32'(exp_gnt));
    chk("m_vld",    32'(bus.gnt_vld_o), 32'(w >= 0));
    chk("m_locked", 32'(bus.locked_o), 32'(exp_lck));
    chk("onehot0",  32'($onehot0(bus.gnt_o)), 32'd1);
    chk("no_req_gnt", 32'(bus.gnt_o & ~bus.req_i), 32'd0);
    for (int i = 0; i < N; i++) begin
      if (rst || !bus.req_i[i]) begin
        wait_cnt[i] <= 0;
      end else if (bus.gnt_vld_o && bus.ack_i) begin
        if (bus.gnt_o[i]) begin
          wait_cnt[i] <= 0;
        end else if (!bus.locked_o) begin
          chk("starve", 32'(wait_cnt[i] < N - 1), 32'd1);
          wait_cnt[i] <= wait_cnt[i] + 1;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic a, input logic l);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.req_i  = r;
    bus.ack_i  = a;
    bus.lock_i = l;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.req_i  = 4'b1111;
    bus.ack_i  = 1'b1;
    bus.lock_i = 1'b1;
    @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt_o), 32'd0);
    chk("rst_vld",    32'(bus.gnt_vld_o), 32'd0);
    chk("rst_locked", 32'(bus.locked_o), 32'd0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("post_rst_pri", 32'(bus.gnt_o), 32'b0001);
  endtask

  logic [N-1:0] exp_seq [5];
  logic [N-1:0] cur;

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    bus.req_i  = '0;
    bus.ack_i  = 1'b0;
    bus.lock_i = 1'b0;

    // Full rotation with wrap.
    do_reset();
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b1, 1'b0);
      chk("rotate", 32'(bus.gnt_o), 32'(exp_seq[i]));
    end
    drive(4'b1111, 1'b1, 1'b0);
    chk("accept_1", 32'(bus.gnt_o), 32'b0010);
    drive(4'b0011, 1'b1, 1'b0);
    chk("wrap_0", 32'(bus.gnt_o), 32'b0001);
    drive(4'b0011, 1'b1, 1'b0);
    chk("wrap_1", 32'(bus.gnt_o), 32'b0010);

    // ack with nothing requested must not move the pointer.
    drive(4'b0000, 1'b1, 1'b0);
    chk("idle_vld", 32'(bus.gnt_vld_o), 32'd0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("idle_keep", 32'(bus.gnt_o), 32'b0100);

    // Grant held without ack; pointer advances only on accept.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0101, 1'b0, 1'b0);
      chk("hold_noack", 32'(bus.gnt_o), 32'b0001);
    end
    drive(4'b0101, 1'b1, 1'b0);
    chk("hold_acc", 32'(bus.gnt_o), 32'b0001);
    drive(4'b0101, 1'b0, 1'b0);
    chk("hold_next", 32'(bus.gnt_o), 32'b0100);

    // Lock held, then released by an unlocked accept.
    do_reset();
    drive(4'b1111, 1'b1, 1'b1);
    chk("lock_take", 32'(bus.gnt_o), 32'b0001);
    chk("lock_take_l", 32'(bus.locked_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1, 1'b1);
      chk("lock_hold", 32'(bus.gnt_o), 32'b0001);
      chk("lock_hold_l", 32'(bus.locked_o), 32'd1);
    end
    drive(4'b1111, 1'b1, 1'b0);
    chk("lock_last", 32'(bus.gnt_o), 32'b0001);
    drive(4'b1111, 1'b0, 1'b0);
    chk("lock_after", 32'(bus.gnt_o), 32'b0010);
    chk("lock_after_l", 32'(bus.locked_o), 32'd0);

    // Lock released by the owner dropping its request.
    do_reset();
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    chk("drop_take", 32'(bus.gnt_o), 32'b0100);
    drive(4'b1111, 1'b0, 1'b0);
    chk("drop_held_l", 32'(bus.locked_o), 32'd1);
    drive(4'b1011, 1'b0, 1'b0);
    chk("drop_gnt", 32'(bus.gnt_o), 32'b1000);
    chk("drop_l", 32'(bus.locked_o), 32'd0);
    drive(4'b1111, 1'b0, 1'b0);
    chk("drop_cleared", 32'(bus.gnt_o), 32'b1000);
    chk("drop_cleared_l", 32'(bus.locked_o), 32'd0);

    // Random sticky requests with occasional resets; the model checks each cycle.
    cur = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) cur[b] = ~cur[b];
      end
      drive(cur, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
